fp_minmax_reduce: RTL
=====================

FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning mantissa field width; W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter IDX_W, default 8, meaning element index/count width.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port bos  input  2  mode: 2'b10 select larger, 2'b01 select smaller, other codes unsupported.
REQ-007 The block SHALL have port in_valid  input  1  input element valid.
REQ-008 The block SHALL have port in_ready  output  1  block accepts element.
REQ-009 The block SHALL have port in_data  input  W  IEEE-style float element {sign, exp, man}.
REQ-010 The block SHALL have port in_last  input  1  marks final element of a vector.
REQ-011 The block SHALL have port out_valid  output  1  result valid.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 The block SHALL have port out_data  output  W  selected value.
REQ-014 The block SHALL have port out_index  output  IDX_W  position of selected value in vector, first element = 0.
REQ-015 The block SHALL have port out_nan  output  1  at least one NaN element seen in vector.
REQ-016 The block SHALL have port out_ovf  output  1  vector exceeded 2^IDX_W elements.

Function
REQ-017 The block SHALL implement states IDLE, ACCUM and HOLD.
REQ-018 A transfer SHALL occur on a clk edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 In IDLE, on transfer: bos SHALL be latched for the whole vector, the element SHALL become the candidate with index 0, and next state SHALL be HOLD if in_last=1, else ACCUM.
REQ-020 bos changes after the first transfer of a vector SHALL have no effect on that vector.
REQ-021 In ACCUM, each transfer SHALL increment the element counter modulo 2^IDX_W and replace the candidate only if the new element is strictly better under the latched mode.
REQ-022 Ties, including +0 versus -0, SHALL keep the earlier element.
REQ-023 Ordering SHALL be total over non-NaN values: key = {1, value[W-2:0]} when sign=0, key = ~value when sign=1; -0 and +0 SHALL be treated as equal; infinities order naturally.
REQ-024 An element with exponent all ones and mantissa non-zero SHALL be treated as NaN: it SHALL never become the candidate and SHALL set the nan flag.
REQ-025 If every element of a vector is NaN, out_data SHALL be the canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, remaining bits 0), out_index SHALL be 0, and out_nan SHALL be 1.
REQ-026 If the counter wraps during a vector, out_ovf SHALL be 1; out_index SHALL then be the low IDX_W bits of the true position.
REQ-027 For an unsupported latched mode, out_data SHALL be 0 and out_index SHALL be 0; out_nan and out_ovf SHALL still be reported.
REQ-028 A transfer with in_last=1 SHALL move the block to HOLD, with out_valid=1 from the next cycle; latency is 1 cycle from the last transfer to out_valid.
REQ-029 The result SHALL include the last element's contribution.
REQ-030 In HOLD, out_data, out_index, out_nan and out_ovf SHALL be stable until the out_valid and out_ready handshake.
REQ-031 On the out_valid and out_ready handshake, the block SHALL return to IDLE with out_valid=0 the next cycle; no input is accepted in that handshake cycle.
REQ-032 A single-element vector SHALL output that element (or canonical NaN), index 0.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, out_valid=0, out_data=0, out_index=0, out_nan=0, out_ovf=0, counter 0 and candidate cleared, and SHALL discard any partial vector.
REQ-034 After rst returns to 1, in_ready SHALL be 1 and the first transfer SHALL start a new vector.

Verification
REQ-035 bos=10, elements 3F800000, C0000000, 40600000(last) -> out_data=40600000, out_index=2, out_nan=0, out_valid the cycle after last.
REQ-036 bos=01, same vector -> out_data=C0000000, out_index=1; bos changed to 10 mid-vector has no effect.
REQ-037 bos=01, elements 00000000, 80000000(last) -> out_data=00000000, out_index=0.
REQ-038 bos=10, elements 7FC00000, 3F800000(last) -> out_data=3F800000, out_index=1, out_nan=1; elements 7F800001, FFC00000(last) -> out_data=7FC00000, out_index=0, out_nan=1.
REQ-039 out_ready held 0 for 3 cycles in HOLD -> out_valid=1 and outputs constant, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-040 IDX_W=2, 5-element vector with max at position 4 -> out_index=0, out_ovf=1; rst=0 mid-vector -> outputs cleared asynchronously and the next vector is computed without residue.

Source files
------------

// File: rtl/fp_minmax_reduce.sv
// Streaming floating-point max/min reduction with element index, NaN and
// overflow flags; one result per vector delivered through a valid/ready hold.
//
// Ports:
//   clk, rst (async, active-low)
//   bos        : 2'b10 selects the larger value, 2'b01 the smaller; other codes unsupported
//   in_valid / in_ready / in_data / in_last : element stream
//   out_valid / out_ready / out_data / out_index / out_nan / out_ovf : result
module fp_minmax_reduce #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int IDX_W = 8,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       bos,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_nan,
   output logic             out_ovf
);

   localparam logic [1:0] MODE_MAX = 2'b10;
   localparam logic [1:0] MODE_MIN = 2'b01;

   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [1:0]       mode_q;
   logic [IDX_W-1:0] cnt_q;
   logic [W-1:0]     cand_q;
   logic [IDX_W-1:0] cand_idx_q;
   logic             cand_ok_q;
   logic             nan_q;
   logic             ovf_q;

   function automatic logic is_nan(input logic [W-1:0] v);
      return (v[W-2:MAN_W] == {EXP_W{1'b1}}) && (v[MAN_W-1:0] != '0);
   endfunction

   // Monotone integer key; both zeros collapse onto the +0 key so
   // that -0 and +0 compare equal.
   function automatic logic [W-1:0] key_of(input logic [W-1:0] v);
      logic [W-1:0] k;
      if (v[W-2:0] == '0)
         k = {1'b1, {(W-1){1'b0}}};
      else if (v[W-1])
         k = ~v;
      else
         k = {1'b1, v[W-2:0]};
      return k;
   endfunction

   logic take;
   logic first;

   assign take  = in_valid && (state != HOLD);
   assign first = (state == IDLE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (take)
               state_nxt = in_last ? HOLD : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (take && in_last)
               state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   logic [1:0]       mode_eff;
   logic [IDX_W-1:0] idx_new;
   logic             wrap;
   logic             base_ok;
   logic             base_nan;
   logic             base_ovf;
   logic             e_nan;
   logic             better;
   logic             supported;
   logic             upd;
   logic [W-1:0]     k_in;
   logic [W-1:0]     k_cand;

   logic [W-1:0]     cand_d;
   logic [IDX_W-1:0] cand_idx_d;
   logic             cand_ok_d;
   logic             nan_d;
   logic             ovf_d;
   logic [W-1:0]     res_data;
   logic [IDX_W-1:0] res_idx;

   always_comb begin
      // The first element of a vector sees a fresh accumulator
      // regardless of leftover register contents.
      mode_eff = first ? bos : mode_q;
      idx_new  = first ? '0 : cnt_q + IDX_W'(1);
      wrap     = !first && (cnt_q == '1);
      base_ok  = first ? 1'b0 : cand_ok_q;
      base_nan = first ? 1'b0 : nan_q;
      base_ovf = first ? 1'b0 : ovf_q;

      e_nan  = is_nan(in_data);
      k_in   = key_of(in_data);
      k_cand = key_of(cand_q);

      better    = 1'b0;
      supported = 1'b0;
      unique case (1'b1)
         (mode_eff == MODE_MAX): begin
            supported = 1'b1;
            better    = k_in > k_cand;
         end
         (mode_eff == MODE_MIN): begin
            supported = 1'b1;
            better    = k_in < k_cand;
         end
         default: begin
            supported = 1'b0;
            better    = 1'b0;
         end
      endcase

      // Strict comparison keeps the earlier element on ties.
      upd = !e_nan && (!base_ok || better);

      cand_d     = upd ? in_data : cand_q;
      cand_idx_d = upd ? idx_new : cand_idx_q;
      cand_ok_d  = base_ok | upd;
      nan_d      = base_nan | e_nan;
      ovf_d      = base_ovf | wrap;

      res_data = '0;
      res_idx  = '0;
      if (supported) begin
         if (cand_ok_d) begin
            res_data = cand_d;
            res_idx  = cand_idx_d;
         end else begin
            res_data = QNAN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q     <= '0;
         cnt_q      <= '0;
         cand_q     <= '0;
         cand_idx_q <= '0;
         cand_ok_q  <= 1'b0;
         nan_q      <= 1'b0;
         ovf_q      <= 1'b0;
         out_data   <= '0;
         out_index  <= '0;
         out_nan    <= 1'b0;
         out_ovf    <= 1'b0;
      end else if (take) begin
         mode_q     <= mode_eff;
         cnt_q      <= idx_new;
         cand_q     <= cand_d;
         cand_idx_q <= cand_idx_d;
         cand_ok_q  <= cand_ok_d;
         nan_q      <= nan_d;
         ovf_q      <= ovf_d;
         if (in_last) begin
            out_data  <= res_data;
            out_index <= res_idx;
            out_nan   <= nan_d;
            out_ovf   <= ovf_d;
         end
      end else if (state == HOLD && out_ready) begin
         out_data  <= '0;
         out_index <= '0;
         out_nan   <= 1'b0;
         out_ovf   <= 1'b0;
      end
   end

endmodule
